// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller poller.
package nes_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    // Bit positions of each button in the 8-bit button word.
    typedef enum logic [2:0] {
        BTN_A,
        BTN_B,
        BTN_SELECT,
        BTN_START,
        BTN_UP,
        BTN_DOWN,
        BTN_LEFT,
        BTN_RIGHT
    } button_t;

    // Encoder output when no button is pressed.
    localparam logic [3:0] NO_BUTTON = 4'hF;

endpackage

// File: rtl/nes_button_encoder.sv
// Lowest-set-bit encoder: returns the index of the lowest pressed button,
// or NO_BUTTON when the word is empty.
module nes_button_encoder
    import nes_pkg::*;
(
    input  logic [7:0] buttons,
    output logic [3:0] idx
);

    // chain[k] holds the answer when only bits k..7 are considered.
    logic [3:0] chain [0:8];

    assign chain[8] = NO_BUTTON;

    genvar gi;
    generate
        for (gi = int'(BTN_A); gi <= int'(BTN_RIGHT); gi++) begin : g_prio
            assign chain[gi] = buttons[gi] ? 4'(gi) : chain[gi+1];
        end
    endgenerate

    assign idx = chain[0];

endmodule

// File: rtl/nes_poll_ctrl.sv
// NES pad sequencer: periodic latch/clock generation, serial sampling,
// and registered button word / lowest-button index with a valid strobe.
module nes_poll_ctrl
    import nes_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic [3:0] button_idx,
    output logic       valid,
    output logic       busy
);

    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int POLL_W    = $clog2(POLL_CYCLES);
    localparam int PHASE_W   = $clog2(PHASE_MAX);

    state_t             state_reg;
    state_t             state_next;
    logic [POLL_W-1:0]  poll_cnt_reg;
    logic [PHASE_W-1:0] phase_cnt_reg;
    logic [2:0]         bit_cnt_reg;
    logic [7:0]         shift_reg;
    logic [7:0]         shift_next;
    logic [3:0]         idx_next;
    logic               data_meta_reg;
    logic               data_sync_reg;
    logic               phase_last;
    logic               sample_en;

    // Two-flop synchronizer for the asynchronous pad data line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
        end else begin
            data_meta_reg <= nes_data;
            data_sync_reg <= data_meta_reg;
        end
    end

    // Free-running frame-start timer, parked at zero while polling is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt_reg <= '0;
        end else if (!enable || poll_cnt_reg == POLL_W'(POLL_CYCLES - 1)) begin
            poll_cnt_reg <= '0;
        end else begin
            poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
        end
    end

    // Last cycle of the current timed phase (LATCH uses its own length).
    always_comb begin
        phase_last = 1'b0;
        if (state_reg == LATCH) begin
            phase_last = (phase_cnt_reg == PHASE_W'(LATCH_CYCLES - 1));
        end else begin
            phase_last = (phase_cnt_reg == PHASE_W'(HALF_CYCLES - 1));
        end
    end

    // Next-state logic and sample strobe.
    always_comb begin
        state_next = state_reg;
        sample_en  = 1'b0;
        case (state_reg)
            IDLE:  if (enable && poll_cnt_reg == '0) state_next = LATCH;
            LATCH: if (phase_last) state_next = LOW;
            LOW: begin
                if (phase_last) begin
                    sample_en  = 1'b1;
                    state_next = (bit_cnt_reg == 3'd7) ? DONE : HIGH;
                end
            end
            HIGH:  if (phase_last) state_next = LOW;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift register view including the bit captured this cycle, so the
    // final bit is already present when the result is registered.
    always_comb begin
        shift_next = shift_reg;
        if (sample_en) begin
            shift_next[bit_cnt_reg] = ~data_sync_reg;
        end
    end

    nes_button_encoder u_encoder (
        .buttons (shift_next),
        .idx     (idx_next)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Phase timer restarts on every state change and stays cleared in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt_reg <= '0;
        end else if (state_next != state_reg || state_reg == IDLE) begin
            phase_cnt_reg <= '0;
        end else begin
            phase_cnt_reg <= phase_cnt_reg + PHASE_W'(1);
        end
    end

    // Bit index and sampled data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else begin
            shift_reg <= shift_next;
            if (state_reg == HIGH && phase_last) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end else if (state_reg == DONE) begin
                bit_cnt_reg <= '0;
            end
        end
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with the state itself. nes_clk stays low through DONE so the frame
    // carries only the seven data-advancing rising edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nes_latch  <= 1'b0;
            nes_clk    <= 1'b1;
            busy       <= 1'b0;
            valid      <= 1'b0;
            buttons    <= 8'h00;
            button_idx <= NO_BUTTON;
        end else begin
            nes_latch <= (state_next == LATCH);
            nes_clk   <= !(state_next == LOW || state_next == DONE);
            busy      <= (state_next != IDLE);
            valid     <= (state_next == DONE);
            if (state_next == DONE) begin
                buttons    <= shift_next;
                button_idx <= idx_next;
            end
        end
    end

endmodule

// File: tb/tb_nes_poll_ctrl.sv
// Bench for nes_poll_ctrl: a behavioural pad model answers the latch/clock
// lines, and a monitor measures frame length, edge counts and pulse timing.
module tb_nes_poll_ctrl;

    localparam int LC = 4;
    localparam int HC = 4;
    localparam int PC = 100;
    localparam int FRAME_LEN = LC + 15 * HC + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       nes_data = 1'b1;
    logic       nes_latch;
    logic       nes_clk;
    logic [7:0] buttons;
    logic [3:0] button_idx;
    logic       valid;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    nes_poll_ctrl #(
        .LATCH_CYCLES (LC),
        .HALF_CYCLES  (HC),
        .POLL_CYCLES  (PC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .nes_data   (nes_data),
        .nes_latch  (nes_latch),
        .nes_clk    (nes_clk),
        .buttons    (buttons),
        .button_idx (button_idx),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Monitor state and pad model state.
    int         cyc = 0;
    int         latch_rise_count = 0;
    int         latch_rise_cycle = 0;
    int         clk_rise_count = 0;
    int         clk_fall_count = 0;
    int         frame_edges = 0;
    int         valid_count = 0;
    int         last_valid_cycle = 0;
    int         prev_valid_cycle = 0;
    int         frame_len_at_valid = 0;
    int         edges_at_valid = 0;
    logic       prev_latch = 1'b0;
    logic       prev_clk = 1'b1;
    logic [7:0] pad_buttons = 8'h00;
    int         pad_idx = 0;

    // Sample DUT outputs mid-cycle; behave like a 4021 shift register pad.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (nes_latch && !prev_latch) begin
            latch_rise_count = latch_rise_count + 1;
            latch_rise_cycle = cyc;
            frame_edges = 0;
        end
        if (nes_clk && !prev_clk) begin
            clk_rise_count = clk_rise_count + 1;
            frame_edges = frame_edges + 1;
        end
        if (!nes_clk && prev_clk) clk_fall_count = clk_fall_count + 1;
        if (valid) begin
            valid_count = valid_count + 1;
            prev_valid_cycle = last_valid_cycle;
            last_valid_cycle = cyc;
            frame_len_at_valid = cyc - latch_rise_cycle + 1;
            edges_at_valid = frame_edges;
        end
        if (nes_latch) pad_idx = 0;
        else if (nes_clk && !prev_clk) pad_idx = pad_idx + 1;
        nes_data = (pad_idx < 8) ? ~pad_buttons[pad_idx] : 1'b1;
        prev_latch = nes_latch;
        prev_clk = nes_clk;
    end

    // Expected index: position of lowest pressed button, 15 if none.
    function automatic logic [3:0] ref_idx(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) return 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        int v0;
        v0 = valid_count;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (valid_count != v0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_latch(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (nes_latch) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        enable = 1'b1;
        repeat (30) tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_midframe_busy: got %b expected 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (nes_latch !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_latch: got %b expected 0", nes_latch);
        end
        tests_run++;
        if (nes_clk !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_clk: got %b expected 1", nes_clk);
        end
        tests_run++;
        if (buttons !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_buttons: got %h expected 00", buttons);
        end
        tests_run++;
        if (button_idx !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_idx: got %h expected f", button_idx);
        end
        tests_run++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid_busy: got %b%b expected 00", valid, busy);
        end
        $display("[TB] reset: latch=%b clk=%b buttons=%h idx=%h", nes_latch, nes_clk, buttons, button_idx);
        repeat (2) tick();
    endtask

    task automatic test_idle_poll();
        bit ok;
        pad_buttons = 8'h00;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(150, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL idle_valid_timeout: frame %0d got no valid expected one", k);
            end
            tests_run++;
            if (buttons !== 8'h00 || button_idx !== 4'hF) begin
                tests_failed++;
                $display("FAIL idle_data: got %h/%h expected 00/f", buttons, button_idx);
            end
            tests_run++;
            if (edges_at_valid != 7) begin
                tests_failed++;
                $display("FAIL idle_clk_edges: got %0d expected 7", edges_at_valid);
            end
            tests_run++;
            if (frame_len_at_valid != FRAME_LEN) begin
                tests_failed++;
                $display("FAIL idle_frame_len: got %0d expected %0d", frame_len_at_valid, FRAME_LEN);
            end
            if (k > 0) begin
                tests_run++;
                if (last_valid_cycle - prev_valid_cycle != PC) begin
                    tests_failed++;
                    $display("FAIL idle_period: got %0d expected %0d", last_valid_cycle - prev_valid_cycle, PC);
                end
            end
            $display("[TB] idle frame %0d: buttons=%h idx=%h len=%0d edges=%0d", k, buttons, button_idx, frame_len_at_valid, edges_at_valid);
        end
    endtask

    task automatic test_patterns();
        bit ok;
        logic [7:0] pats [8];
        pats[0] = 8'h08;
        pats[1] = 8'h81;
        pats[2] = 8'h80;
        pats[3] = 8'hFF;
        for (int i = 4; i < 8; i++) pats[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            pad_buttons = pats[i];
            wait_valid(150, ok);
            tests_run++;
            if (!ok || buttons !== pats[i] || button_idx !== ref_idx(pats[i])) begin
                tests_failed++;
                $display("FAIL pattern_%0d: got %h/%h expected %h/%h", i, buttons, button_idx, pats[i], ref_idx(pats[i]));
            end
            tests_run++;
            if (frame_len_at_valid != FRAME_LEN) begin
                tests_failed++;
                $display("FAIL pattern_len_%0d: got %0d expected %0d", i, frame_len_at_valid, FRAME_LEN);
            end
            $display("[TB] pattern %0d: pad=%h buttons=%h idx=%h", i, pats[i], buttons, button_idx);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int f0;
        int v0;
        logic [7:0] pa;
        pa = 8'($urandom_range(1, 255));
        pad_buttons = pa;
        wait_latch(150, ok);
        f0 = clk_fall_count;
        for (int i = 0; i < 150 && clk_fall_count - f0 < 5; i++) tick();
        tests_run++;
        if (!ok || clk_fall_count - f0 != 5) begin
            tests_failed++;
            $display("FAIL abort_reach_low5: got %0d falls expected 5", clk_fall_count - f0);
        end
        repeat (2) tick();
        v0 = valid_count;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (nes_latch !== 1'b0 || nes_clk !== 1'b1 || busy !== 1'b0 || valid !== 1'b0
            || buttons !== 8'h00 || button_idx !== 4'hF) begin
            tests_failed++;
            $display("FAIL abort_outputs: got l%b c%b b%b v%b %h/%h expected l0 c1 b0 v0 00/f",
                     nes_latch, nes_clk, busy, valid, buttons, button_idx);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tests_run++;
        if (valid_count != v0) begin
            tests_failed++;
            $display("FAIL abort_no_valid: got %0d pulses expected 0", valid_count - v0);
        end
        wait_valid(150, ok);
        tests_run++;
        if (!ok || buttons !== pa || button_idx !== ref_idx(pa) || frame_len_at_valid != FRAME_LEN) begin
            tests_failed++;
            $display("FAIL abort_recover: got %h/%h len %0d expected %h/%h len %0d",
                     buttons, button_idx, frame_len_at_valid, pa, ref_idx(pa), FRAME_LEN);
        end
        $display("[TB] reset abort: recovered buttons=%h idx=%h", buttons, button_idx);
    endtask

    task automatic test_enable_drop();
        bit ok;
        int r0;
        int l0;
        int v0;
        logic [7:0] pe;
        pe = 8'($urandom_range(1, 255));
        pad_buttons = pe;
        wait_latch(150, ok);
        r0 = clk_rise_count;
        for (int i = 0; i < 150 && clk_rise_count - r0 < 3; i++) tick();
        tick();
        enable = 1'b0;
        v0 = valid_count;
        wait_valid(150, ok);
        tests_run++;
        if (!ok || buttons !== pe || button_idx !== ref_idx(pe) || frame_len_at_valid != FRAME_LEN) begin
            tests_failed++;
            $display("FAIL drop_complete: got %h/%h len %0d expected %h/%h len %0d",
                     buttons, button_idx, frame_len_at_valid, pe, ref_idx(pe), FRAME_LEN);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || valid_count - v0 != 1) begin
            tests_failed++;
            $display("FAIL drop_idle: got busy %b pulses %0d expected busy 0 pulses 1", busy, valid_count - v0);
        end
        l0 = latch_rise_count;
        v0 = valid_count;
        repeat (250) tick();
        tests_run++;
        if (latch_rise_count != l0 || valid_count != v0) begin
            tests_failed++;
            $display("FAIL drop_quiet: got %0d latches %0d valids expected 0 0", latch_rise_count - l0, valid_count - v0);
        end
        enable = 1'b1;
        wait_latch(3, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL drop_restart: got no latch expected latch within 3 cycles");
        end
        wait_valid(150, ok);
        tests_run++;
        if (!ok || buttons !== pe) begin
            tests_failed++;
            $display("FAIL drop_restart_data: got %h expected %h", buttons, pe);
        end
        $display("[TB] enable drop: buttons=%h idx=%h", buttons, button_idx);
    endtask

    initial begin
        test_reset();
        test_idle_poll();
        test_patterns();
        test_reset_abort();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
